// File: rtl/patbuf_write_arbiter.sv
// Pattern buffer write-port arbiter: shares one write port between single-field
// writes from the PAT core and full-pattern bursts from the loader. PAT and the
// loader alternate on the port when both want it in the same cycle.
module patbuf_write_arbiter #(
    parameter int unsigned BUF_WIDTH   = 8,
    parameter int unsigned NO_FIELDS   = 22,
    parameter int unsigned NO_BUFS     = 8,
    parameter int unsigned BUF_PTR_W   = (NO_BUFS > 1) ? $clog2(NO_BUFS) : 1,
    parameter int unsigned FIELD_PTR_W = (NO_FIELDS > 1) ? $clog2(NO_FIELDS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pat_req,
    input  logic [BUF_PTR_W-1:0]   pat_buf,
    input  logic [FIELD_PTR_W-1:0] pat_field,
    input  logic [BUF_WIDTH-1:0]   pat_data,
    output logic                   pat_gnt,
    output logic                   pat_err,
    input  logic                   ld_start,
    input  logic [BUF_PTR_W-1:0]   ld_buf,
    input  logic                   ld_valid,
    input  logic [BUF_WIDTH-1:0]   ld_data,
    output logic                   ld_ready,
    output logic                   ld_busy,
    output logic                   ld_done,
    output logic [BUF_PTR_W-1:0]   bufp_out,
    output logic [FIELD_PTR_W-1:0] fieldwp_out,
    output logic [BUF_WIDTH-1:0]   field_in_out,
    output logic                   field_write_out
);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    localparam logic [FIELD_PTR_W-1:0] LastField = FIELD_PTR_W'(NO_FIELDS - 1);

    state_e                 state_q, state_d;
    logic [FIELD_PTR_W-1:0] cnt_q, cnt_d;
    logic [BUF_PTR_W-1:0]   ld_buf_q, ld_buf_d;
    logic                   prio_pat_q, prio_pat_d;
    logic                   ld_acc;
    logic                   pat_field_ok;

    // Grants: outside LOAD the PAT side owns the port; inside LOAD prio_pat breaks ties.
    assign pat_gnt      = pat_req && ((state_q != StLoad) || !ld_valid || prio_pat_q);
    assign ld_ready     = (state_q == StLoad) && !(pat_req && prio_pat_q);
    assign ld_acc       = ld_valid && ld_ready;
    assign pat_field_ok = 32'(pat_field) < NO_FIELDS;

    // Burst FSM, field counter, latched target buffer and fairness toggle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ld_buf_d   = ld_buf_q;
        prio_pat_d = prio_pat_q;
        unique case (state_q)
            StIdle: begin
                if (ld_start) begin
                    ld_buf_d = ld_buf;
                    cnt_d    = '0;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                // Only a contended cycle flips priority.
                if (pat_req && ld_valid) begin
                    prio_pat_d = !prio_pat_q;
                end
                if (ld_acc) begin
                    if (cnt_q == LastField) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ld_buf_q   <= '0;
            prio_pat_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ld_buf_q   <= ld_buf_d;
            prio_pat_q <= prio_pat_d;
        end
    end

    // Registered write port and status; pointers/data hold when no write happens.
    always_ff @(posedge clk) begin
        if (rst) begin
            bufp_out        <= '0;
            fieldwp_out     <= '0;
            field_in_out    <= '0;
            field_write_out <= 1'b0;
            pat_err         <= 1'b0;
            ld_busy         <= 1'b0;
            ld_done         <= 1'b0;
        end else begin
            field_write_out <= 1'b0;
            pat_err         <= 1'b0;
            if (pat_gnt) begin
                // Out-of-range field: consume the request but drop the write.
                if (pat_field_ok) begin
                    bufp_out        <= pat_buf;
                    fieldwp_out     <= pat_field;
                    field_in_out    <= pat_data;
                    field_write_out <= 1'b1;
                end else begin
                    pat_err <= 1'b1;
                end
            end else if (ld_acc) begin
                bufp_out        <= ld_buf_q;
                fieldwp_out     <= cnt_q;
                field_in_out    <= ld_data;
                field_write_out <= 1'b1;
            end
            ld_busy <= (state_d != StIdle);
            ld_done <= (state_d == StDone);
        end
    end

endmodule
